// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates the CPU fetch and data ports onto one byte-wide external RAM.
// Define MEM_CTRL_IFETCH_BUF_EN to add a single-entry instruction fetch buffer.
`timescale 1ns/1ps
module mem_ctrl #(
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              rom_ready_o,
    input  logic              ram_ce_i,
    input  logic              ram_we_i,
    input  logic [31:0]       ram_addr_i,
    input  logic [3:0]        ram_sel_i,
    input  logic [31:0]       ram_data_i,
    output logic [31:0]       ram_data_o,
    output logic              ram_ready_o,
    output logic              stallreq_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_next;
    logic              owner_rom;
    logic              we_q;
    logic [31:2]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        sel_q;
    logic [1:0]        issue_cnt;
    logic              issue_done;
    logic [1:0]        cap_cnt;
    logic [RD_LAT-1:0] rd_pipe;
    logic [31:0]       asm_word;
    logic [31:0]       rom_word;
    logic [31:0]       ram_word;
    logic [31:0]       buf_word;
    logic              buf_hit;
    logic              accept_ram;
    logic              accept_rom;
    logic              issuing_rd;
    logic              issuing_wr;
    logic              capture;
    logic              unused_bits;

    // Data port wins arbitration; requests are only looked at while idle.
    assign accept_ram = (state == IDLE) && ram_ce_i;
    assign accept_rom = (state == IDLE) && !ram_ce_i && rom_ce_i;
    assign issuing_rd = (state == READ) && !issue_done;
    assign issuing_wr = (state == WRITE);
    assign capture    = (state == READ) && rd_pipe[RD_LAT-1];

    assign unused_bits = ^{rom_addr_i[1:0], ram_addr_i[1:0], addr_q[31:ADDR_W]};

`ifdef MEM_CTRL_IFETCH_BUF_EN
    logic        buf_valid;
    logic [31:2] buf_tag;

    assign buf_hit = buf_valid && (buf_tag == rom_addr_i[31:2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_word  <= '0;
        end else if (state == DONE && owner_rom) begin
            buf_valid <= 1'b1;
            buf_tag   <= addr_q;
            buf_word  <= asm_word;
        end else if (accept_ram && ram_we_i && (buf_tag == ram_addr_i[31:2])) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_ram) begin
                    state_next = ram_we_i ? WRITE : READ;
                end else if (accept_rom) begin
                    state_next = buf_hit ? DONE : READ;
                end
            end
            READ: begin
                if (capture && cap_cnt == 2'd3) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                if (issue_cnt == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are zero whenever no byte is being issued.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (issuing_rd || issuing_wr) begin
            mem_a = {addr_q[ADDR_W-1:2], issue_cnt};
        end
        if (issuing_wr) begin
            mem_dout = wdata_q[{issue_cnt, 3'b000} +: 8];
            mem_wr   = sel_q[issue_cnt];
        end
    end

    assign rom_ready_o = (state == DONE) && owner_rom;
    assign ram_ready_o = (state == DONE) && !owner_rom;
    assign rom_data_o  = rom_ready_o ? asm_word : rom_word;
    assign ram_data_o  = (ram_ready_o && !we_q) ? asm_word : ram_word;
    assign stallreq_o  = (rom_ce_i & ~rom_ready_o) | (ram_ce_i & ~ram_ready_o);

    // rd_pipe tracks which issued addresses have data arriving RD_LAT cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_rom  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            cap_cnt    <= '0;
            rd_pipe    <= '0;
            asm_word   <= '0;
            rom_word   <= '0;
            ram_word   <= '0;
        end else begin
            rd_pipe[0] <= issuing_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            case (state)
                IDLE: begin
                    if (accept_ram || accept_rom) begin
                        owner_rom  <= !ram_ce_i;
                        addr_q     <= ram_ce_i ? ram_addr_i[31:2] : rom_addr_i[31:2];
                        we_q       <= ram_ce_i && ram_we_i;
                        wdata_q    <= ram_data_i;
                        sel_q      <= ram_sel_i;
                        issue_cnt  <= '0;
                        issue_done <= 1'b0;
                        cap_cnt    <= '0;
                        if (accept_rom && buf_hit) begin
                            asm_word <= buf_word;
                        end
                    end
                end
                READ: begin
                    if (issuing_rd) begin
                        issue_cnt <= issue_cnt + 2'd1;
                        if (issue_cnt == 2'd3) begin
                            issue_done <= 1'b1;
                        end
                    end
                    if (capture) begin
                        asm_word[{cap_cnt, 3'b000} +: 8] <= mem_din;
                        cap_cnt <= cap_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    issue_cnt <= issue_cnt + 2'd1;
                end
                DONE: begin
                    if (owner_rom) begin
                        rom_word <= asm_word;
                    end else if (!we_q) begin
                        ram_word <= asm_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte-wide RAM models at RD_LAT 1 and 3, reference memory for expected words.
`timescale 1ns/1ps
module tb_mem_ctrl;

    localparam int ADDR_W = 17;
`ifdef MEM_CTRL_IFETCH_BUF_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_ACT = 0;
`else
    localparam int HIT_LAT = 6;
    localparam int HIT_ACT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              rom_ce, ram_ce, ram_we;
    logic [31:0]       rom_addr, ram_addr, ram_wdata;
    logic [3:0]        ram_sel;
    logic [31:0]       rom_data_o, ram_data_o;
    logic              rom_ready_o, ram_ready_o, stallreq_o;
    logic [7:0]        mem_din, mem_dout;
    logic [ADDR_W-1:0] mem_a, a_d1;
    logic              mem_wr;

    logic              rom_ce3;
    logic [31:0]       rom_addr3;
    logic [31:0]       rom_data3, ram_data3;
    logic              rom_ready3, ram_ready3, stall3;
    logic [7:0]        mem_din3, mem_dout3;
    logic [ADDR_W-1:0] mem_a3, a3_d1, a3_d2, a3_d3;
    logic              mem_wr3;

    mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data_o), .rom_ready_o(rom_ready_o),
        .ram_ce_i(ram_ce), .ram_we_i(ram_we), .ram_addr_i(ram_addr), .ram_sel_i(ram_sel),
        .ram_data_i(ram_wdata), .ram_data_o(ram_data_o), .ram_ready_o(ram_ready_o),
        .stallreq_o(stallreq_o), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce3), .rom_addr_i(rom_addr3), .rom_data_o(rom_data3), .rom_ready_o(rom_ready3),
        .ram_ce_i(1'b0), .ram_we_i(1'b0), .ram_addr_i(32'h0), .ram_sel_i(4'h0),
        .ram_data_i(32'h0), .ram_data_o(ram_data3), .ram_ready_o(ram_ready3),
        .stallreq_o(stall3), .mem_din(mem_din3), .mem_dout(mem_dout3), .mem_a(mem_a3), .mem_wr(mem_wr3)
    );

    logic [7:0]  ext_mem  [0:4095];
    logic [7:0]  ext_mem3 [0:4095];
    logic [7:0]  ref_mem  [0:4095];
    logic [7:0]  dout_seen [0:15];
    logic [31:0] rom_q[$];
    logic [31:0] ram_q[$];
    logic [31:0] last_rom, last_ram;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // External RAM models: write on the strobe, read data appears RD_LAT cycles after the address.
    always @(posedge clk) begin
        a_d1 <= mem_a;
        if (mem_wr) ext_mem[mem_a[11:0]] = mem_dout;
        a3_d1 <= mem_a3;
        a3_d2 <= a3_d1;
        a3_d3 <= a3_d2;
        if (mem_wr3) ext_mem3[mem_a3[11:0]] = mem_dout3;
    end
    assign mem_din  = ext_mem[a_d1[11:0]];
    assign mem_din3 = ext_mem3[a3_d3[11:0]];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refWord(input logic [31:0] a);
        return {ref_mem[12'(a + 3)], ref_mem[12'(a + 2)], ref_mem[12'(a + 1)], ref_mem[a[11:0]]};
    endfunction

    // Scoreboard: every ready pulse must match the oldest queued expectation for that port.
    always @(negedge clk) begin
        if (rom_ready_o) begin
            if (rom_q.size() == 0) checkOutput("rom_unexpected_ready", 32'd1, 32'd0);
            else checkOutput("rom_data", rom_data_o, rom_q.pop_front());
        end
        if (ram_ready_o) begin
            if (ram_q.size() == 0) checkOutput("ram_unexpected_ready", 32'd1, 32'd0);
            else checkOutput("ram_data", ram_data_o, ram_q.pop_front());
        end
    end

    // kind: 0 fetch, 1 data read, 2 data write. Called just after a rising edge with the controller idle.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] sel, input int exp_lat, input string tag,
                                 output logic [15:0] wmask, output logic active);
        int   acc, rel, got_lat, stall_bad;
        logic rdy, done;
        wmask = '0; active = 1'b0; got_lat = -1; stall_bad = 0; done = 1'b0;
        for (int i = 0; i < 16; i++) dout_seen[i] = 8'h0;
        if (kind == 0) begin
            rom_addr = addr;
            rom_ce   = 1'b1;
            last_rom = refWord(addr);
            rom_q.push_back(last_rom);
        end else begin
            ram_addr  = addr;
            ram_we    = (kind == 2);
            ram_sel   = sel;
            ram_wdata = wdata;
            ram_ce    = 1'b1;
            if (kind == 1) begin
                last_ram = refWord(addr);
            end else begin
                for (int k = 0; k < 4; k++)
                    if (sel[k]) ref_mem[12'(addr + k)] = wdata[8*k +: 8];
            end
            ram_q.push_back(last_ram);
        end
        acc = cyc + 1;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            rel = cyc - acc + 1;
            rdy = (kind == 0) ? rom_ready_o : ram_ready_o;
            if (rel >= 1 && rel < 16) begin
                if (mem_wr) wmask[rel] = 1'b1;
                dout_seen[rel] = mem_dout;
                if (mem_a != '0) active = 1'b1;
            end
            if (stallreq_o !== (rel != exp_lat)) stall_bad++;
            if (rdy) begin
                got_lat = rel;
                done = 1'b1;
            end
        end
        checkOutput({tag, "_ready_cycle"}, got_lat, exp_lat);
        checkOutput({tag, "_stall"}, stall_bad, 0);
        @(posedge clk); #1;
        rom_ce = 1'b0;
        ram_ce = 1'b0;
    endtask

    initial begin
        logic [15:0] wm;
        logic        act;
        int          acc, rel, ram_lat, rom_lat, stall_bad, wr_bad, lat3;
        logic [31:0] data3;

        rom_ce = 0; ram_ce = 0; ram_we = 0; rom_addr = 0; ram_addr = 0; ram_sel = 0; ram_wdata = 0;
        rom_ce3 = 0; rom_addr3 = 0; last_rom = 0; last_ram = 0;
        for (int i = 0; i < 4096; i++) begin
            ext_mem[i] = 8'h0; ext_mem3[i] = 8'h0; ref_mem[i] = 8'h0;
        end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w100, w40, w0;
            w100 = 32'h0010_0513; w40 = 32'h4433_2211; w0 = 32'h0000_0093;
            ext_mem[12'h100 + k] = w100[8*k +: 8]; ref_mem[12'h100 + k] = w100[8*k +: 8];
            ext_mem3[12'h100 + k] = w100[8*k +: 8];
            ext_mem[12'h040 + k] = w40[8*k +: 8];  ref_mem[12'h040 + k] = w40[8*k +: 8];
            ext_mem[12'h000 + k] = w0[8*k +: 8];   ref_mem[12'h000 + k] = w0[8*k +: 8];
        end

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_rom_data", rom_data_o, 32'h0);
        checkOutput("rst_ram_data", ram_data_o, 32'h0);
        checkOutput("rst_mem_a", {15'h0, mem_a}, 32'h0);
        checkOutput("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        checkOutput("rst_ready", {30'h0, rom_ready_o, ram_ready_o}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] fetch of 0x100");
        applyStimulus(0, 32'h100, 32'h0, 4'h0, 6, "fetch1", wm, act);

        $display("[TB] partial write then read back");
        applyStimulus(2, 32'h200, 32'hAABB_CCDD, 4'b0101, 5, "wr200", wm, act);
        checkOutput("wr200_strobes", {16'h0, wm}, 32'h0000_000A);
        checkOutput("wr200_byte0", {24'h0, dout_seen[1]}, 32'hDD);
        checkOutput("wr200_byte2", {24'h0, dout_seen[3]}, 32'hBB);
        applyStimulus(1, 32'h200, 32'h0, 4'h0, 6, "rd200", wm, act);

        $display("[TB] simultaneous fetch and data read");
        rom_addr = 32'h0; rom_ce = 1'b1; last_rom = refWord(32'h0); rom_q.push_back(last_rom);
        ram_addr = 32'h40; ram_we = 1'b0; ram_ce = 1'b1; last_ram = refWord(32'h40); ram_q.push_back(last_ram);
        acc = cyc + 1; ram_lat = -1; rom_lat = -1; stall_bad = 0;
        for (int n = 0; n < 40 && rom_lat < 0; n++) begin
            @(negedge clk);
            rel = cyc - acc + 1;
            if (stallreq_o !== (rel != 13)) stall_bad++;
            if (ram_ready_o && ram_lat < 0) ram_lat = rel;
            if (rom_ready_o && rom_lat < 0) rom_lat = rel;
            @(posedge clk); #1;
            if (ram_lat >= 0) ram_ce = 1'b0;
            if (rom_lat >= 0) rom_ce = 1'b0;
        end
        rom_ce = 1'b0; ram_ce = 1'b0;
        checkOutput("prio_ram_ready_cycle", ram_lat, 6);
        checkOutput("prio_rom_ready_cycle", rom_lat, 13);
        checkOutput("prio_stall", stall_bad, 0);

        $display("[TB] repeated fetch and fetch after overwrite");
        applyStimulus(0, 32'h100, 32'h0, 4'h0, 6, "fetch2", wm, act);
        checkOutput("fetch2_bus_active", {31'h0, act}, 32'd1);
        applyStimulus(0, 32'h100, 32'h0, 4'h0, HIT_LAT, "fetch3", wm, act);
        checkOutput("fetch3_bus_active", {31'h0, act}, HIT_ACT);
        applyStimulus(2, 32'h100, 32'hCAFE_F00D, 4'b1111, 5, "wr100", wm, act);
        checkOutput("wr100_strobes", {16'h0, wm}, 32'h0000_001E);
        applyStimulus(0, 32'h100, 32'h0, 4'h0, 6, "fetch4", wm, act);

        $display("[TB] reset during a write");
        ram_addr = 32'h280; ram_we = 1'b1; ram_sel = 4'hF; ram_wdata = 32'h1122_3344; ram_ce = 1'b1;
        acc = cyc + 1;
        for (int n = 0; n < 10 && cyc < acc + 2; n++) begin
            @(posedge clk); #1;
        end
        #2;
        checkOutput("pre_rst_mem_wr", {31'h0, mem_wr}, 32'd1);
        rst = 1'b0; ram_ce = 1'b0;
        #1;
        checkOutput("async_rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        checkOutput("async_rst_mem_a", {15'h0, mem_a}, 32'h0);
        checkOutput("async_rst_mem_dout", {24'h0, mem_dout}, 32'h0);
        checkOutput("async_rst_rom_data", rom_data_o, 32'h0);
        checkOutput("async_rst_ram_data", ram_data_o, 32'h0);
        checkOutput("async_rst_ready", {30'h0, rom_ready_o, ram_ready_o}, 32'h0);
        ram_q.delete(); rom_q.delete(); last_rom = 0; last_ram = 0;
        wr_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr) wr_bad++;
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (mem_wr) wr_bad++;
        end
        checkOutput("rst_no_wr", wr_bad, 0);
        @(posedge clk); #1;
        applyStimulus(0, 32'h100, 32'h0, 4'h0, 6, "fetch_after_rst", wm, act);

        $display("[TB] fetch with RD_LAT 3");
        rom_addr3 = 32'h100; rom_ce3 = 1'b1;
        acc = cyc + 1; lat3 = -1; data3 = 32'h0;
        for (int n = 0; n < 30 && lat3 < 0; n++) begin
            @(negedge clk);
            if (rom_ready3) begin
                lat3 = cyc - acc + 1;
                data3 = rom_data3;
            end
        end
        @(posedge clk); #1 rom_ce3 = 1'b0;
        checkOutput("lat3_ready_cycle", lat3, 8);
        checkOutput("lat3_data", data3, 32'h0010_0513);

        repeat (2) @(posedge clk);
        checkOutput("rom_queue_drained", rom_q.size(), 0);
        checkOutput("ram_queue_drained", ram_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the CPU core's 32-bit instruction (`rom_*`) and data (`ram_*`) ports and a single-port, byte-wide external RAM. It arbitrates the two ports onto one byte bus, serialises every word access into four byte transfers, and raises a stall request while either port is waiting. The stall request goes to the pipeline stall controller.

## Interface
- `ADDR_W`, 17: external byte-address width.
- `RD_LAT`, 1: external read latency in cycles (1..3), from address driven to `mem_din` valid.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `rom_ce_i`  in  1  instruction fetch request; held until `rom_ready_o`.
- `rom_addr_i`  in  32  fetch byte address, word aligned.
- `rom_data_o`  out  32  fetched instruction word.
- `rom_ready_o`  out  1  one-cycle pulse when `rom_data_o` is valid.
- `ram_ce_i`  in  1  data request; held until `ram_ready_o`.
- `ram_we_i`  in  1  1 = write, 0 = read.
- `ram_addr_i`  in  32  data byte address, word aligned.
- `ram_sel_i`  in  4  byte enables for writes; bit k selects byte k.
- `ram_data_i`  in  32  write data.
- `ram_data_o`  out  32  read data.
- `ram_ready_o`  out  1  one-cycle completion pulse.
- `stallreq_o`  out  1  a port is requesting and not yet ready.
- `mem_din`  in  8  external read byte.
- `mem_dout`  out  8  external write byte.
- `mem_a`  out  ADDR_W  external byte address; `addr[ADDR_W-1:0]`.
- `mem_wr`  out  1  external write strobe.

## Operation
- States are `IDLE`, `READ`, `WRITE` and `DONE`.
- **Arbitration.** Requests are sampled only in `IDLE`. A data request has priority over an instruction request. The accepted address, data, sel and we are latched at acceptance, and later input changes are ignored until `DONE`.
- **Transitions.**
  - `IDLE` goes to `READ` on a fetch or a data read.
  - `IDLE` goes to `WRITE` on a data write.
  - `READ` and `WRITE` go to `DONE` after the last byte.
  - `DONE` goes to `IDLE` unconditionally, so there is one idle cycle between transactions.
- **Read.** A 2-bit issue counter drives `mem_a = base + k` for k = 0..3. A separate capture counter stores `mem_din` into byte k of the assembly register `RD_LAT` cycles later. Bytes are little-endian: byte 0 goes to [7:0].
- **Write.**
  - Four cycles are always used, k = 0..3.
  - `mem_a = base + k` and `mem_dout = data[8k+7:8k]`.
  - `mem_wr = sel[k]`, so unselected bytes are skipped on the bus but still consume their cycle.
- **`DONE`.** Pulses the ready output of the owning port. On reads, the assembled word is written to `rom_data_o` or `ram_data_o`, and that output holds until the next read completes on the same port.
- **`stallreq_o`.** Defined as `(rom_ce_i & ~rom_ready_o) | (ram_ce_i & ~ram_ready_o)`; it is combinational.
- **Address arithmetic.** `base + k` never carries into bit 2 because addresses are aligned. Address bits above `ADDR_W` are discarded.
- **Reset, asserted at any time including mid-transfer:**
  - state goes to `IDLE` and counters clear;
  - `mem_wr`, `mem_a`, `mem_dout`, `rom_data_o`, `ram_data_o` and both ready outputs go to 0;
  - the fetch buffer is invalidated.
- When the bus is idle, `mem_wr` = 0 and `mem_a` and `mem_dout` hold 0.

## Timing
- The request is accepted at edge t0, in `IDLE`.
- Byte k address is driven in cycle t0+1+k.
- **Read.** Byte k is captured at the end of cycle t0+1+k+RD_LAT, and ready is high in cycle t0+5+RD_LAT. With the default `RD_LAT` this is 6 cycles after acceptance.
- **Write.** Ready is high in cycle t0+5.
- **Simultaneous requests in `IDLE`.** The data request is served first. The fetch is accepted in the `IDLE` cycle after the data request's `DONE`, and `stallreq_o` stays high throughout.

## Configuration
- **`MEM_CTRL_IFETCH_BUF_EN` defined:**
  - A single-entry fetch buffer (tag, word, valid) is filled on every completed fetch.
  - A fetch accepted in `IDLE` that hits a valid tag skips `READ`. The state goes straight to `DONE` with the buffered word, so ready comes at t0+1.
  - Any data write whose word address matches the tag clears valid when the write is accepted.
- **Undefined:** the buffer logic is absent and every fetch takes the full `READ` sequence.

## Test plan
- **Fetch.** Memory bytes 0x100..0x103 = 13,05,10,00; fetch 0x100. Require `rom_data_o` = 0x00100513 and `rom_ready_o` high exactly at t0+6, with `stallreq_o` high from request until ready.
- **Partial write, then read.** Write 0xAABBCCDD to 0x200 with sel = 0101. Require `mem_wr` high only in cycles t0+1 and t0+3 (bytes DD, BB) and ready at t0+5. A subsequent read of a word preset to 0 returns 0x00BB00DD.
- **Priority.** Assert a fetch of 0x0 and a read of 0x40 in the same cycle. Require `ram_ready_o` before `rom_ready_o`, the fetch accepted one cycle after the data `DONE`, and no lost request.
- **Reset mid-transfer.** Drop `rst` during issue of byte 2 of a write. Require all outputs 0 immediately (asynchronously), no further `mem_wr` pulses, and after release the next request completes normally.
- **`RD_LAT` = 3.** Fetch 0x100. Require ready at t0+8 and correct byte order.
- **With `MEM_CTRL_IFETCH_BUF_EN`.**
  - Fetching 0x100 twice: the second fetch has ready at t0+1 with no `mem_a` activity.
  - Writing 0x100, then fetching it again: the fetch takes the full 6 cycles and returns the new data.
